// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one single-byte I2C master core between two requesters.
// Optional macro I2C_ARB_RETRY_EN re-issues a failed command up to RETRY_MAX times before reporting.
module i2c_master_arbiter #(
    parameter int BUSY_TIMEOUT = 64,
    parameter int IDLE_GAP     = 50,
    parameter int RETRY_MAX    = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [1:0] i_Req_Valid,
    input  logic [1:0] i_Req_Rw,
    input  logic [6:0] i_Req0_Addr,
    input  logic [7:0] i_Req0_Data,
    input  logic [6:0] i_Req1_Addr,
    input  logic [7:0] i_Req1_Data,
    output logic [1:0] o_Req_Ack,
    output logic [1:0] o_Req_Done,
    output logic       o_Req_Error,
    output logic [7:0] o_Rd_Byte,
    output logic       o_Arb_Busy,
    output logic [6:0] o_Mst_Slave_Addr,
    output logic [7:0] o_Mst_Wr_Byte,
    output logic       o_Mst_Wr_Start,
    output logic       o_Mst_Rd_Start,
    input  logic       i_Mst_Busy,
    input  logic [7:0] i_Mst_Rd_Byte,
    input  logic       i_Mst_Error,
    output logic [2:0] o_Dbg_State
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4,
        S_GAP       = 3'd5
    } state_e;

`ifdef I2C_ARB_RETRY_EN
    localparam int RETRY_LIM = RETRY_MAX;
`else
    // Retries compiled out: a zero limit sends the first error straight to RESP.
    localparam int RETRY_LIM = 0 * RETRY_MAX;
`endif

    localparam logic [15:0] BUSY_LIM = 16'(BUSY_TIMEOUT);
    localparam logic [15:0] GAP_LIM  = 16'(IDLE_GAP - 1);

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        ptr_q, ptr_d;
    logic        gnt_q, gnt_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  rd_byte_q, rd_byte_d;
    logic        wr_start_q, wr_start_d;
    logic        rd_start_q, rd_start_d;
    logic [7:0]  retry_cnt_q, retry_cnt_d;
    logic        retry_pend_q, retry_pend_d;

    logic        any_req;
    logic        gnt_sel;
    logic        retry_ok;
    logic        retry_go;
    logic [15:0] timer_inc;

    // Handshake: a requester holds i_Req_Valid until its one-cycle o_Req_Ack; the command is
    // latched on that ack and the requester's inputs are ignored until its o_Req_Done pulse.
    always_comb begin
        any_req   = |i_Req_Valid;
        gnt_sel   = i_Req_Valid[ptr_q] ? ptr_q : ~ptr_q;
        retry_ok  = ({24'd0, retry_cnt_q} < 32'(RETRY_LIM));
        timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        retry_go = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT_BUSY;
                timer_d = 16'd0;
            end
            S_WAIT_BUSY: begin
                timer_d = timer_inc;
                if (i_Mst_Busy) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q >= BUSY_LIM) begin
                    if (retry_ok) begin
                        state_d  = S_GAP;
                        timer_d  = 16'd0;
                        retry_go = 1'b1;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!i_Mst_Busy) begin
                    if (i_Mst_Error && retry_ok) begin
                        state_d  = S_GAP;
                        timer_d  = 16'd0;
                        retry_go = 1'b1;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                state_d = S_GAP;
                timer_d = 16'd0;
            end
            S_GAP: begin
                timer_d = timer_inc;
                if (timer_q >= GAP_LIM) begin
                    state_d = retry_pend_q ? S_START : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        data_d       = data_q;
        ack_d        = 2'b00;
        done_d       = 2'b00;
        err_d        = 1'b0;
        rd_byte_d    = rd_byte_q;
        wr_start_d   = 1'b0;
        rd_start_d   = 1'b0;
        retry_cnt_d  = retry_cnt_q;
        retry_pend_d = retry_pend_q;

        if (state_q == S_IDLE && any_req) begin
            gnt_d        = gnt_sel;
            ptr_d        = ~gnt_sel;
            ack_d        = gnt_sel ? 2'b10 : 2'b01;
            rw_d         = i_Req_Rw[gnt_sel];
            addr_d       = gnt_sel ? i_Req1_Addr : i_Req0_Addr;
            data_d       = gnt_sel ? i_Req1_Data : i_Req0_Data;
            retry_cnt_d  = 8'd0;
            retry_pend_d = 1'b0;
        end

        if (state_q == S_START) begin
            wr_start_d = ~rw_q;
            rd_start_d = rw_q;
        end

        // Done/error/byte are registered on entry to RESP so they appear during the RESP cycle.
        if (state_d == S_RESP && state_q != S_RESP) begin
            done_d = gnt_q ? 2'b10 : 2'b01;
            err_d  = (state_q == S_WAIT_BUSY) ? 1'b1 : i_Mst_Error;
            if (rw_q && state_q == S_WAIT_DONE) begin
                rd_byte_d = i_Mst_Rd_Byte;
            end
        end

        if (retry_go) begin
            retry_cnt_d  = (retry_cnt_q == 8'hFF) ? retry_cnt_q : retry_cnt_q + 8'd1;
            retry_pend_d = 1'b1;
        end else if (state_q == S_GAP && state_d != S_GAP) begin
            retry_pend_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            timer_q      <= 16'd0;
            ptr_q        <= 1'b0;
            gnt_q        <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= 7'd0;
            data_q       <= 8'd0;
            ack_q        <= 2'b00;
            done_q       <= 2'b00;
            err_q        <= 1'b0;
            rd_byte_q    <= 8'd0;
            wr_start_q   <= 1'b0;
            rd_start_q   <= 1'b0;
            retry_cnt_q  <= 8'd0;
            retry_pend_q <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rd_byte_q    <= rd_byte_d;
            wr_start_q   <= wr_start_d;
            rd_start_q   <= rd_start_d;
            retry_cnt_q  <= retry_cnt_d;
            retry_pend_q <= retry_pend_d;
        end
    end

    assign o_Req_Ack        = ack_q;
    assign o_Req_Done       = done_q;
    assign o_Req_Error      = err_q;
    assign o_Rd_Byte        = rd_byte_q;
    assign o_Arb_Busy       = (state_q != S_IDLE);
    assign o_Mst_Slave_Addr = addr_q;
    assign o_Mst_Wr_Byte    = data_q;
    assign o_Mst_Wr_Start   = wr_start_q;
    assign o_Mst_Rd_Start   = rd_start_q;
    assign o_Dbg_State      = state_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with a behavioural single-byte core model.
// Address 0x22 is NACKed by the model; core_dead ties busy low to force timeouts.
module tb_i2c_master_arbiter;

    localparam int BT  = 8;
    localparam int GAP = 4;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic [1:0] i_Req_Valid = 2'b00;
    logic [1:0] i_Req_Rw = 2'b00;
    logic [6:0] i_Req0_Addr = 7'd0;
    logic [7:0] i_Req0_Data = 8'd0;
    logic [6:0] i_Req1_Addr = 7'd0;
    logic [7:0] i_Req1_Data = 8'd0;
    logic       i_Mst_Busy = 1'b0;
    logic [7:0] i_Mst_Rd_Byte = 8'd0;
    logic       i_Mst_Error = 1'b0;
    logic [1:0] o_Req_Ack, o_Req_Done;
    logic       o_Req_Error, o_Arb_Busy, o_Mst_Wr_Start, o_Mst_Rd_Start;
    logic [7:0] o_Rd_Byte, o_Mst_Wr_Byte;
    logic [6:0] o_Mst_Slave_Addr;
    logic [2:0] o_Dbg_State;

    i2c_master_arbiter #(.BUSY_TIMEOUT(BT), .IDLE_GAP(GAP), .RETRY_MAX(1)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst),
        .i_Req_Valid(i_Req_Valid), .i_Req_Rw(i_Req_Rw),
        .i_Req0_Addr(i_Req0_Addr), .i_Req0_Data(i_Req0_Data),
        .i_Req1_Addr(i_Req1_Addr), .i_Req1_Data(i_Req1_Data),
        .o_Req_Ack(o_Req_Ack), .o_Req_Done(o_Req_Done), .o_Req_Error(o_Req_Error),
        .o_Rd_Byte(o_Rd_Byte), .o_Arb_Busy(o_Arb_Busy),
        .o_Mst_Slave_Addr(o_Mst_Slave_Addr), .o_Mst_Wr_Byte(o_Mst_Wr_Byte),
        .o_Mst_Wr_Start(o_Mst_Wr_Start), .o_Mst_Rd_Start(o_Mst_Rd_Start),
        .i_Mst_Busy(i_Mst_Busy), .i_Mst_Rd_Byte(i_Mst_Rd_Byte), .i_Mst_Error(i_Mst_Error),
        .o_Dbg_State(o_Dbg_State)
    );

    // clock / reset
    always #5 i_Clk = ~i_Clk;

    int cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // core model and event log, all on the falling edge
    logic core_dead = 1'b0;
    logic core_rd   = 1'b0;
    int   core_cnt  = 0;
    int   st_n = 0, st_cyc = 0, st_cyc_prev = 0, done_n = 0;
    logic st_rd_last = 1'b0;

    always @(negedge i_Clk) begin
        if (i_Rst) begin
            i_Mst_Busy    = 1'b0;
            i_Mst_Error   = 1'b0;
            i_Mst_Rd_Byte = 8'd0;
            core_cnt      = 0;
        end else begin
            if (o_Mst_Wr_Start || o_Mst_Rd_Start) begin
                st_n++;
                st_cyc_prev = st_cyc;
                st_cyc      = cyc;
                st_rd_last  = o_Mst_Rd_Start;
            end
            if (o_Req_Done != 2'b00) done_n++;
            if (i_Mst_Busy) begin
                if (core_cnt == 0) begin
                    i_Mst_Busy    = 1'b0;
                    i_Mst_Error   = (o_Mst_Slave_Addr == 7'h22);
                    i_Mst_Rd_Byte = core_rd ? 8'h5A : 8'hEE;
                end else begin
                    core_cnt--;
                end
            end else if ((o_Mst_Wr_Start || o_Mst_Rd_Start) && !core_dead) begin
                i_Mst_Busy  = 1'b1;
                i_Mst_Error = 1'b0;
                core_cnt    = 4;
                core_rd     = o_Mst_Rd_Start;
            end
        end
    end

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 32'(o_Req_Ack), 0);
        check({tag, "_done"}, 32'(o_Req_Done), 0);
        check({tag, "_err"}, 32'(o_Req_Error), 0);
        check({tag, "_rdbyte"}, 32'(o_Rd_Byte), 0);
        check({tag, "_busy"}, 32'(o_Arb_Busy), 0);
        check({tag, "_addr"}, 32'(o_Mst_Slave_Addr), 0);
        check({tag, "_wrbyte"}, 32'(o_Mst_Wr_Byte), 0);
        check({tag, "_starts"}, 32'({o_Mst_Wr_Start, o_Mst_Rd_Start}), 0);
        check({tag, "_state"}, 32'(o_Dbg_State), 0);
    endtask

    // driver tasks
    task automatic drive_req(input int idx, input logic rw, input logic [6:0] a,
                             input logic [7:0] d);
        if (idx == 0) begin
            i_Req0_Addr = a;
            i_Req0_Data = d;
        end else begin
            i_Req1_Addr = a;
            i_Req1_Data = d;
        end
        i_Req_Rw[idx]    = rw;
        i_Req_Valid[idx] = 1'b1;
    endtask

    task automatic wait_ack(input string tag, output logic [1:0] ack, output int acyc);
        bit found = 0;
        ack  = 2'b00;
        acyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge i_Clk);
            if (o_Req_Ack != 2'b00) begin
                ack   = o_Req_Ack;
                acyc  = cyc;
                found = 1;
                break;
            end
        end
        if (!found) check({tag, "_ack_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string tag, output logic [1:0] done, output logic err,
                             output logic [7:0] rd, output int dcyc);
        bit found = 0;
        done = 2'b00;
        err  = 1'b0;
        rd   = 8'd0;
        dcyc = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge i_Clk);
            if (o_Req_Done != 2'b00) begin
                done  = o_Req_Done;
                err   = o_Req_Error;
                rd    = o_Rd_Byte;
                dcyc  = cyc;
                found = 1;
                break;
            end
        end
        if (!found) check({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        bit found = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge i_Clk);
            if (!o_Arb_Busy) begin
                found = 1;
                break;
            end
        end
        if (!found) check({tag, "_idle_timeout"}, 0, 1);
    endtask

    task automatic single(input string tag, input int idx, input logic rw, input logic [6:0] a,
                          input logic [7:0] d, output int c0, output logic [1:0] ack,
                          output int acyc);
        @(posedge i_Clk);
        #1;
        drive_req(idx, rw, a, d);
        c0 = cyc;
        wait_ack(tag, ack, acyc);
        i_Req_Valid = 2'b00;
    endtask

    task automatic pulse_reset();
        @(negedge i_Clk);
        i_Rst = 1'b1;
        repeat (2) @(negedge i_Clk);
        i_Rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] ack, done;
        logic       err;
        logic [7:0] rd;
        int         c0, acyc, dcyc, st0, dn0;
        bit         found;

        // reset state
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        check_all_zero("reset");
        i_Rst = 1'b0;

        // T1: req0 write 0x51 / 0xAC
        single("t1", 0, 1'b0, 7'h51, 8'hAC, c0, ack, acyc);
        check("t1_ack", 32'(ack), 32'h1);
        check("t1_ack_lat", acyc, c0 + 1);
        check("t1_arb_busy", 32'(o_Arb_Busy), 1);
        check("t1_addr", 32'(o_Mst_Slave_Addr), 32'h51);
        check("t1_wrbyte", 32'(o_Mst_Wr_Byte), 32'hAC);
        wait_done("t1", done, err, rd, dcyc);
        check("t1_done", 32'(done), 32'h1);
        check("t1_err", 32'(err), 0);
        check("t1_rd_unchanged", 32'(rd), 0);
        check("t1_start_lat", st_cyc, c0 + 2);
        check("t1_start_kind_rd", 32'(st_rd_last), 0);
        check("t1_start_count", st_n, 1);
        wait_idle("t1");

        // T2: both requesters in the same cycle straight after reset
        pulse_reset();
        st0 = st_n;
        @(posedge i_Clk);
        #1;
        drive_req(0, 1'b0, 7'h10, 8'h11);
        drive_req(1, 1'b0, 7'h20, 8'h22);
        wait_ack("t2a", ack, acyc);
        i_Req_Valid[0] = 1'b0;
        check("t2_first_ack", 32'(ack), 32'h1);
        check("t2_first_addr", 32'(o_Mst_Slave_Addr), 32'h10);
        wait_done("t2a", done, err, rd, dcyc);
        check("t2_first_done", 32'(done), 32'h1);
        wait_ack("t2b", ack, acyc);
        i_Req_Valid[1] = 1'b0;
        check("t2_second_ack", 32'(ack), 32'h2);
        check("t2_second_addr", 32'(o_Mst_Slave_Addr), 32'h20);
        check("t2_second_wrbyte", 32'(o_Mst_Wr_Byte), 32'h22);
        wait_done("t2b", done, err, rd, dcyc);
        check("t2_second_done", 32'(done), 32'h2);
        check("t2_start_count", st_n - st0, 2);
        check("t2_start_spacing_ok", 32'((st_cyc - st_cyc_prev) >= GAP + 2), 1);
        wait_idle("t2");

        // T3: req1 read, slave returns 0x5A
        single("t3", 1, 1'b1, 7'h51, 8'h00, c0, ack, acyc);
        check("t3_ack", 32'(ack), 32'h2);
        wait_done("t3", done, err, rd, dcyc);
        check("t3_done", 32'(done), 32'h2);
        check("t3_err", 32'(err), 0);
        check("t3_rdbyte", 32'(rd), 32'h5A);
        check("t3_start_kind_rd", 32'(st_rd_last), 1);
        wait_idle("t3");
        check("t3_rdbyte_held", 32'(o_Rd_Byte), 32'h5A);

        // T4: core never raises busy -> timeout error, then normal service resumes
        core_dead = 1'b1;
        single("t4", 0, 1'b0, 7'h33, 8'h44, c0, ack, acyc);
        wait_done("t4", done, err, rd, dcyc);
        check("t4_done", 32'(done), 32'h1);
        check("t4_err", 32'(err), 1);
`ifndef I2C_ARB_RETRY_EN
        check("t4_timeout_lat", dcyc, c0 + BT + 3);
`endif
        core_dead = 1'b0;
        wait_idle("t4");
        single("t4b", 1, 1'b0, 7'h34, 8'h55, c0, ack, acyc);
        check("t4b_ack", 32'(ack), 32'h2);
        wait_done("t4b", done, err, rd, dcyc);
        check("t4b_done", 32'(done), 32'h2);
        check("t4b_err", 32'(err), 0);
        check("t4b_rd_kept_on_write", 32'(rd), 32'h5A);
        wait_idle("t4b");

        // T5: NACKed address 0x22
        st0 = st_n;
        single("t5", 0, 1'b0, 7'h22, 8'h99, c0, ack, acyc);
        wait_done("t5", done, err, rd, dcyc);
        check("t5_done", 32'(done), 32'h1);
        check("t5_err", 32'(err), 1);
`ifdef I2C_ARB_RETRY_EN
        check("t5_start_count", st_n - st0, 2);
`else
        check("t5_start_count", st_n - st0, 1);
`endif
        wait_idle("t5");

        // T6: reset while waiting for the core to finish
        single("t6", 0, 1'b1, 7'h51, 8'h00, c0, ack, acyc);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (o_Dbg_State == 3'd3) begin
                found = 1;
                break;
            end
            @(negedge i_Clk);
        end
        check("t6_reached_wait_done", 32'(found), 1);
        dn0 = done_n;
        i_Rst = 1'b1;
        #1;
        check_all_zero("t6_async");
        @(posedge i_Clk);
        #1;
        check_all_zero("t6_edge");
        repeat (3) @(negedge i_Clk);
        i_Rst = 1'b0;
        check("t6_no_done", done_n, dn0);
        single("t6b", 1, 1'b0, 7'h51, 8'h3C, c0, ack, acyc);
        check("t6b_ack", 32'(ack), 32'h2);
        check("t6b_wrbyte", 32'(o_Mst_Wr_Byte), 32'h3C);
        wait_done("t6b", done, err, rd, dcyc);
        check("t6b_done", 32'(done), 32'h2);
        check("t6b_err", 32'(err), 0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
